// File: rtl/alu_serial_seq_if.sv
// Handshake and operand/result bus for the bit-serial ALU sequencer.
// The master issues Start with operands; the slave reports Ready/Done and
// the registered result and flags.
interface alu_serial_seq_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, alu_ctl, a, b,
    input  ready, done, result, zero, overflow, carry_out
  );

  modport slave (
    input  start, alu_ctl, a, b,
    output ready, done, result, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: pushes one operand bit pair per cycle through a
// single 1-bit ALU slice, LSB first, and assembles the WIDTH-bit result.
// SLT runs the slice as a subtract and fixes up the sign with the overflow.
module alu_serial_seq #(
  parameter int WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_serial_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-2:0] rsh_q, rsh_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d;

  // Slice drive and response
  logic       sl_a, sl_b, sl_ainv, sl_binv, sl_cin, sl_less;
  logic [1:0] sl_op;
  logic       sl_res, sl_cout;
  logic       accept;
  logic [WIDTH-1:0] word, fin;

  // Slice inputs: SLT is run as a subtract pass, LESS is never used
  always_comb begin
    sl_a    = sa_q[0];
    sl_b    = sb_q[0];
    sl_ainv = ctl_q[3];
    sl_binv = ctl_q[2];
    sl_cin  = carry_q;
    sl_less = 1'b0;
    sl_op   = (ctl_q == 4'b0111) ? 2'b10 : ctl_q[1:0];
  end

  // The 1-bit ALU slice itself
  always_comb begin
    logic aa, bb;
    aa      = sl_a ^ sl_ainv;
    bb      = sl_b ^ sl_binv;
    sl_cout = (aa & bb) | (sl_cin & (aa ^ bb));
    unique case (sl_op)
      2'b00:   sl_res = aa & bb;
      2'b01:   sl_res = aa | bb;
      2'b10:   sl_res = aa ^ bb ^ sl_cin;
      default: sl_res = sl_less;
    endcase
  end

  // Next-state, shift datapath and completion results
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rsh_d    = rsh_q;
    ctl_d    = ctl_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    accept   = (state_q != S_RUN) && bus.start;
    word     = {sl_res, rsh_q};
    fin      = '0;

    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        rsh_d   = word[WIDTH-1:1];
        carry_d = sl_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          ovf_d   = 1'b0;
          cout_d  = 1'b0;
          unique case (ctl_q)
            4'b0000, 4'b0001, 4'b1100: fin = word;
            4'b0010, 4'b0110: begin
              fin    = word;
              ovf_d  = carry_q ^ sl_cout;
              cout_d = sl_cout;
            end
            // sign of the difference, corrected when the subtract overflowed
            4'b0111: fin = {{(WIDTH-1){1'b0}}, sl_res ^ carry_q ^ sl_cout};
            default: fin = '0;
          endcase
          result_d = fin;
          zero_d   = (fin == '0);
        end
      end
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture operands; BInvert doubles as the bit-0 carry-in
    if (accept) begin
      sa_d    = bus.a;
      sb_d    = bus.b;
      ctl_d   = bus.alu_ctl;
      cnt_d   = '0;
      carry_d = bus.alu_ctl[2];
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      rsh_q    <= '0;
      ctl_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rsh_q    <= rsh_d;
      ctl_q    <= ctl_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.ready     = (state_q != S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for the bit-serial ALU sequencer.
module tb_alu_serial_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_serial_seq_if #(.WIDTH(24)) bus ();
  alu_serial_seq #(.WIDTH(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Issue one op (accepted at the next edge), scramble inputs, wait for Done
  task automatic do_op(input logic [3:0] ctl, input logic [23:0] a, input logic [23:0] b,
                       output int lat);
    bus.start = 1'b1; bus.alu_ctl = ctl; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 24'($urandom); bus.b = 24'($urandom); bus.alu_ctl = 4'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst ready: got %b exp 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst done: got %b exp 0", bus.done); end
    checks++; if ({bus.result, bus.zero, bus.overflow, bus.carry_out} !== 27'h0) begin errors++;
      $display("FAIL rst outputs: got %h %b%b%b exp 0", bus.result, bus.zero, bus.overflow, bus.carry_out); end
    #10 rst_n = 1'b1;  // released mid-cycle, next edge may accept
  endtask

  task automatic test_add();
    int lat;
    do_op(4'b0010, 24'h7FFFFF, 24'h000001, lat);
    checks++; if (lat !== 24) begin errors++; $display("FAIL add latency: got %0d exp 24", lat); end
    checks++; if (bus.result !== 24'h800000) begin errors++; $display("FAIL add1 result: got %h exp 800000", bus.result); end
    checks++; if ({bus.overflow, bus.carry_out, bus.zero} !== 3'b100) begin errors++;
      $display("FAIL add1 flags ovf/co/z: got %b exp 100", {bus.overflow, bus.carry_out, bus.zero}); end
    do_op(4'b0010, 24'hFFFFFF, 24'h000001, lat);
    checks++; if (bus.result !== 24'h000000) begin errors++; $display("FAIL add2 result: got %h exp 000000", bus.result); end
    checks++; if ({bus.overflow, bus.carry_out, bus.zero} !== 3'b011) begin errors++;
      $display("FAIL add2 flags ovf/co/z: got %b exp 011", {bus.overflow, bus.carry_out, bus.zero}); end
  endtask

  task automatic test_sub();
    int lat;
    do_op(4'b0110, 24'h000005, 24'h000005, lat);
    checks++; if (bus.result !== 24'h000000) begin errors++; $display("FAIL sub1 result: got %h exp 000000", bus.result); end
    checks++; if ({bus.overflow, bus.carry_out, bus.zero} !== 3'b011) begin errors++;
      $display("FAIL sub1 flags ovf/co/z: got %b exp 011", {bus.overflow, bus.carry_out, bus.zero}); end
    do_op(4'b0110, 24'h000003, 24'h000005, lat);
    checks++; if (bus.result !== 24'hFFFFFE) begin errors++; $display("FAIL sub2 result: got %h exp fffffe", bus.result); end
    checks++; if ({bus.overflow, bus.carry_out, bus.zero} !== 3'b000) begin errors++;
      $display("FAIL sub2 flags ovf/co/z: got %b exp 000", {bus.overflow, bus.carry_out, bus.zero}); end
  endtask

  task automatic test_slt();
    int lat;
    do_op(4'b0111, 24'hFFFFFF, 24'h000001, lat);
    checks++; if (bus.result !== 24'h000001) begin errors++; $display("FAIL slt1 result: got %h exp 000001", bus.result); end
    do_op(4'b0111, 24'h800000, 24'h7FFFFF, lat);
    checks++; if (bus.result !== 24'h000001) begin errors++; $display("FAIL slt_ovf result: got %h exp 000001", bus.result); end
    checks++; if ({bus.overflow, bus.carry_out, bus.zero} !== 3'b000) begin errors++;
      $display("FAIL slt_ovf flags ovf/co/z: got %b exp 000", {bus.overflow, bus.carry_out, bus.zero}); end
    do_op(4'b0111, 24'h7FFFFF, 24'h800000, lat);
    checks++; if (bus.result !== 24'h000000) begin errors++; $display("FAIL slt_swap result: got %h exp 000000", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL slt_swap zero: got %b exp 1", bus.zero); end
  endtask

  task automatic test_logic();
    int lat;
    do_op(4'b0000, 24'hF0F0F0, 24'h0FF00F, lat);
    checks++; if (bus.result !== 24'h00F000) begin errors++; $display("FAIL and result: got %h exp 00f000", bus.result); end
    do_op(4'b0001, 24'hF0F0F0, 24'h0FF00F, lat);
    checks++; if (bus.result !== 24'hFFF0FF) begin errors++; $display("FAIL or result: got %h exp fff0ff", bus.result); end
    do_op(4'b1100, 24'hF0F0F0, 24'h0FF00F, lat);
    checks++; if (bus.result !== 24'h000F00) begin errors++; $display("FAIL nor result: got %h exp 000f00", bus.result); end
    checks++; if ({bus.overflow, bus.carry_out, bus.zero} !== 3'b000) begin errors++;
      $display("FAIL nor flags ovf/co/z: got %b exp 000", {bus.overflow, bus.carry_out, bus.zero}); end
    do_op(4'b0011, 24'hF0F0F0, 24'h0FF00F, lat);
    checks++; if (lat !== 24) begin errors++; $display("FAIL bad_ctl latency: got %0d exp 24", lat); end
    checks++; if ({bus.result, bus.zero} !== {24'h0, 1'b1}) begin errors++;
      $display("FAIL bad_ctl result/zero: got %h %b exp 000000 1", bus.result, bus.zero); end
  endtask

  task automatic test_start_ignored();
    int lat;
    bus.start = 1'b1; bus.alu_ctl = 4'b0010; bus.a = 24'h000100; bus.b = 24'h000023;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL run ready: got %b exp 0", bus.ready); end
    bus.start = 1'b1; bus.alu_ctl = 4'b0000; bus.a = 24'h123456; bus.b = 24'h654321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 11;
    while (bus.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 24) begin errors++; $display("FAIL ign latency: got %0d exp 24", lat); end
    checks++; if (bus.result !== 24'h000123) begin errors++; $display("FAIL ign result: got %h exp 000123", bus.result); end
    @(posedge clk); #1;
    checks++; if ({bus.done, bus.ready} !== 2'b01) begin errors++;
      $display("FAIL done_pulse done/ready: got %b exp 01", {bus.done, bus.ready}); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.result !== 24'h000123) begin errors++; $display("FAIL hold result: got %h exp 000123", bus.result); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(4'b0010, 24'h000001, 24'h000002, lat);
    bus.start = 1'b1; bus.alu_ctl = 4'b0010; bus.a = 24'h000010; bus.b = 24'h000014;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if ({bus.done, bus.ready} !== 2'b00) begin errors++;
      $display("FAIL b2b after accept done/ready: got %b exp 00", {bus.done, bus.ready}); end
    checks++; if (bus.result !== 24'h000003) begin errors++; $display("FAIL b2b held result: got %h exp 000003", bus.result); end
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 25) begin errors++; $display("FAIL b2b spacing: got %0d exp 25", lat); end
    checks++; if (bus.result !== 24'h000024) begin errors++; $display("FAIL b2b result: got %h exp 000024", bus.result); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    do_op(4'b0010, 24'h7FFFFF, 24'h000001, lat);  // leaves non-zero result and Overflow=1
    bus.start = 1'b1; bus.alu_ctl = 4'b0010; bus.a = 24'h000001; bus.b = 24'h000001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.ready, bus.done} !== 2'b10) begin errors++;
      $display("FAIL midrst ready/done: got %b exp 10", {bus.ready, bus.done}); end
    checks++; if ({bus.result, bus.zero, bus.overflow, bus.carry_out} !== 27'h0) begin errors++;
      $display("FAIL midrst outputs: got %h %b%b%b exp 0", bus.result, bus.zero, bus.overflow, bus.carry_out); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.done === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst stray done: got %0d exp 0", seen); end
    do_op(4'b0001, 24'h00A000, 24'h00000B, lat);
    checks++; if (lat !== 24 || bus.result !== 24'h00A00B) begin errors++;
      $display("FAIL post_rst op lat/result: got %0d %h exp 24 00a00b", lat, bus.result); end
  endtask

  initial begin
    bus.start = 1'b0; bus.alu_ctl = 4'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
